// File: rtl/boot_loader.sv
// Framed byte-stream program loader: writes a checksummed image into instruction
// memory word by word and holds the CPU in reset until the image is verified.
module boot_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [15:0]       imem_wdata,
   output logic              cpu_run,
   output logic              err
);

   localparam logic [7:0] HDR = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_HI,
      S_LO,
      S_CSUM,
      S_RUN
   } state_t;

   state_t              state, state_n;
   logic [7:0]          len, len_n;
   logic [7:0]          hi, hi_n;
   logic [7:0]          csum, csum_n;
   logic [ADDR_W-1:0]   cnt, cnt_n;
   logic [ADDR_W-1:0]   addr_n;
   logic [15:0]         wdata_n;
   logic                we_n;
   logic                run_n;
   logic                err_n;
   logic                take;

   // Every state except the terminal one accepts bytes
   assign rx_ready = (state != S_RUN);
   assign take     = rx_valid && rx_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         len        <= '0;
         hi         <= '0;
         csum       <= '0;
         cnt        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_run    <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         len        <= len_n;
         hi         <= hi_n;
         csum       <= csum_n;
         cnt        <= cnt_n;
         imem_we    <= we_n;
         imem_addr  <= addr_n;
         imem_wdata <= wdata_n;
         cpu_run    <= run_n;
         err        <= err_n;
      end
   end

   // Frame parser: next state, datapath updates and write request
   always_comb begin
      state_n = state;
      len_n   = len;
      hi_n    = hi;
      csum_n  = csum;
      cnt_n   = cnt;
      we_n    = 1'b0;
      addr_n  = imem_addr;
      wdata_n = imem_wdata;
      err_n   = err;

      if (take) begin
         case (state)
            S_IDLE: begin
               if (rx_data == HDR) begin
                  err_n   = 1'b0;
                  state_n = S_LEN;
               end
            end
            S_LEN: begin
               if (rx_data == 8'd0) begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  len_n   = rx_data;
                  cnt_n   = '0;
                  csum_n  = '0;
                  state_n = S_HI;
               end
            end
            S_HI: begin
               hi_n    = rx_data;
               csum_n  = csum + rx_data;
               state_n = S_LO;
            end
            S_LO: begin
               csum_n  = csum + rx_data;
               we_n    = 1'b1;
               addr_n  = cnt;
               wdata_n = {hi, rx_data};
               if (cnt == ADDR_W'(len - 8'd1)) begin
                  state_n = S_CSUM;
               end else begin
                  cnt_n   = cnt + ADDR_W'(1);
                  state_n = S_HI;
               end
            end
            S_CSUM: begin
               if (rx_data == csum) begin
                  state_n = S_RUN;
               end else begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end
            end
            default: ;
         endcase
      end

      // Released only once the verified image is complete
      run_n = (state_n == S_RUN);
   end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: byte streams are parsed by a frame-level
// reference model that predicts writes and per-byte err/cpu_run/strobe values.
module tb_boot_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int          BUD    = 20;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_wdata;
   logic              cpu_run;
   logic              err;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  stream[$];
   logic [23:0] exp_wr[$];
   logic [23:0] got_wr[$];
   bit          m_we  [2048];
   bit          m_err [2048];
   bit          m_run [2048];
   int          m_n;

   always #5 clk = ~clk;

   boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .err        (err)
   );

   // Write monitor
   always @(negedge clk) begin
      if (rst && imem_we) got_wr.push_back({imem_addr, imem_wdata});
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void rec(int idx, bit we, bit e, bit r);
      m_we[idx]  = we;
      m_err[idx] = e;
      m_run[idx] = r;
   endfunction

   // Frame-level reference: scans the stream for frames and predicts outcomes
   function automatic void model_parse();
      int         i = 0;
      int         n = stream.size();
      int         nw;
      bit         e = 1'b0;
      bit         run = 1'b0;
      bit         done = 1'b0;
      logic [7:0] sum;
      logic [7:0] hb;
      exp_wr.delete();
      while (i < n && !run && !done) begin
         if (stream[i] != 8'hA5) begin
            rec(i, 1'b0, e, 1'b0);
            i++;
         end else begin
            e = 1'b0;
            rec(i, 1'b0, e, 1'b0);
            i++;
            if (i >= n) done = 1'b1;
            else begin
               nw = int'(stream[i]);
               if (nw == 0) e = 1'b1;
               rec(i, 1'b0, e, 1'b0);
               i++;
               if (nw != 0) begin
                  sum = 8'd0;
                  for (int w = 0; w < nw && !done; w++) begin
                     if (i >= n) done = 1'b1;
                     else begin
                        hb = stream[i];
                        rec(i, 1'b0, e, 1'b0);
                        i++;
                        if (i >= n) done = 1'b1;
                        else begin
                           rec(i, 1'b1, e, 1'b0);
                           exp_wr.push_back({8'(w), hb, stream[i]});
                           sum = sum + hb + stream[i];
                           i++;
                        end
                     end
                  end
                  if (!done) begin
                     if (i >= n) done = 1'b1;
                     else begin
                        if (stream[i] == sum) run = 1'b1;
                        else e = 1'b1;
                        rec(i, 1'b0, e, run);
                        i++;
                     end
                  end
               end
            end
         end
      end
      m_n = i;
   endfunction

   task automatic do_reset(input bit chk, input string name);
      @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b0;
      #1;
      if (chk) begin
         checks++; if (rx_ready !== 1'b1) begin failures++; $display("FAIL %s rx_ready got %b exp 1", name, rx_ready); end
         checks++; if (imem_we !== 1'b0) begin failures++; $display("FAIL %s imem_we got %b exp 0", name, imem_we); end
         checks++; if (imem_addr !== '0) begin failures++; $display("FAIL %s imem_addr got %h exp 0", name, imem_addr); end
         checks++; if (imem_wdata !== 16'h0) begin failures++; $display("FAIL %s imem_wdata got %h exp 0", name, imem_wdata); end
         checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL %s cpu_run got %b exp 0", name, cpu_run); end
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL %s err got %b exp 0", name, err); end
      end
      @(negedge clk);
      rst = 1'b1;
      got_wr.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input string name, output bit ok);
      int t = 0;
      repeat (gap) @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      while (rx_ready !== 1'b1 && t < BUD) begin
         @(negedge clk);
         t++;
      end
      if (rx_ready !== 1'b1) begin
         checks++; failures++;
         $display("FAIL %s byte %h not accepted within %0d cycles", name, b, BUD);
         rx_valid = 1'b0;
         ok = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic run_bytes(input int from, input int to, input int maxgap, input string name);
      bit ok;
      int gap;
      for (int k = from; k < to && k < m_n; k++) begin
         gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         send_byte(stream[k], gap, name, ok);
         if (!ok) return;
         checks++;
         if (imem_we !== m_we[k]) begin failures++; $display("FAIL %s imem_we after byte %0d got %b exp %b", name, k, imem_we, m_we[k]); end
         checks++;
         if (err !== m_err[k]) begin failures++; $display("FAIL %s err after byte %0d got %b exp %b", name, k, err, m_err[k]); end
         checks++;
         if (cpu_run !== m_run[k]) begin failures++; $display("FAIL %s cpu_run after byte %0d got %b exp %b", name, k, cpu_run, m_run[k]); end
      end
   endtask

   task automatic check_final(input string name);
      int  nw;
      bit  run_exp;
      run_exp = (m_n > 0) ? m_run[m_n-1] : 1'b0;
      @(negedge clk);
      checks++;
      if (rx_ready !== !run_exp) begin failures++; $display("FAIL %s rx_ready got %b exp %b", name, rx_ready, !run_exp); end
      checks++;
      if (got_wr.size() != exp_wr.size()) begin
         failures++; $display("FAIL %s write count got %0d exp %0d", name, got_wr.size(), exp_wr.size());
      end
      nw = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
      for (int i = 0; i < nw; i++) begin
         checks++;
         if (got_wr[i] !== exp_wr[i]) begin
            failures++; $display("FAIL %s write %0d got addr %h data %h exp addr %h data %h",
                                 name, i, got_wr[i][23:16], got_wr[i][15:0], exp_wr[i][23:16], exp_wr[i][15:0]);
         end
      end
      if (run_exp) begin
         nw = got_wr.size();
         rx_valid = 1'b1;
         rx_data  = 8'hA5;
         repeat (4) begin
            @(negedge clk);
            checks++;
            if (rx_ready !== 1'b0 || cpu_run !== 1'b1) begin
               failures++; $display("FAIL %s in RUN rx_ready got %b exp 0 cpu_run got %b exp 1", name, rx_ready, cpu_run);
            end
         end
         rx_valid = 1'b0;
         checks++;
         if (got_wr.size() != nw) begin failures++; $display("FAIL %s writes while running got %0d exp %0d", name, got_wr.size(), nw); end
      end
   endtask

   task automatic load_list(input logic [7:0] b[]);
      stream.delete();
      foreach (b[i]) stream.push_back(b[i]);
      model_parse();
   endtask

   task automatic test_reset();
      do_reset(1'b1, "reset");
   endtask

   task automatic test_basic();
      do_reset(1'b0, "basic");
      load_list('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE});
      checks++;
      if (exp_wr.size() != 2 || exp_wr[0] !== 24'h001234 || exp_wr[1] !== 24'h01ABCD || m_run[6] !== 1'b1) begin
         failures++; $display("FAIL basic_model writes %0d run %b exp 2 writes and run 1", exp_wr.size(), m_run[6]);
      end
      run_bytes(0, stream.size(), 0, "basic");
      check_final("basic");
   endtask

   task automatic test_bad_then_good();
      do_reset(1'b0, "bad_csum");
      load_list('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF,
                  8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE});
      run_bytes(0, 7, 0, "bad_csum");
      checks++;
      if (rx_ready !== 1'b1 || err !== 1'b1 || cpu_run !== 1'b0 || got_wr.size() != 2) begin
         failures++; $display("FAIL bad_csum mid rx_ready %b err %b run %b writes %0d exp 1 1 0 2", rx_ready, err, cpu_run, got_wr.size());
      end
      run_bytes(7, stream.size(), 0, "bad_then_good");
      check_final("bad_then_good");
   endtask

   task automatic test_garbage();
      do_reset(1'b0, "garbage");
      load_list('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'h07, 8'h07});
      run_bytes(0, stream.size(), 0, "garbage");
      check_final("garbage");
   endtask

   task automatic test_zero_len();
      do_reset(1'b0, "zero_len");
      load_list('{8'hA5, 8'h00});
      run_bytes(0, stream.size(), 0, "zero_len");
      check_final("zero_len");
   endtask

   task automatic test_gapped();
      for (int r = 0; r < 3; r++) begin
         do_reset(1'b0, "gapped");
         load_list('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE});
         run_bytes(0, stream.size(), 5, "gapped");
         check_final("gapped");
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0, "reset_mid");
      load_list('{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE});
      run_bytes(0, 5, 0, "reset_mid");
      do_reset(1'b1, "reset_mid_values");
      run_bytes(0, stream.size(), 0, "reset_mid_reload");
      check_final("reset_mid_reload");
   endtask

   task automatic test_full_length();
      int total = 0;
      do_reset(1'b0, "full");
      stream.delete();
      stream.push_back(8'hA5);
      stream.push_back(8'hFF);
      for (int i = 0; i < 510; i++) begin
         stream.push_back(8'(i % 254));
         total += i % 254;
      end
      stream.push_back(8'(total % 256));
      model_parse();
      checks++;
      if (exp_wr.size() != 255 || exp_wr[254][23:16] !== 8'd254 || m_run[stream.size()-1] !== 1'b1) begin
         failures++; $display("FAIL full_model writes %0d run %b exp 255 writes and run 1", exp_wr.size(), m_run[stream.size()-1]);
      end
      run_bytes(0, stream.size(), 0, "full");
      check_final("full");
   endtask

   task automatic test_random();
      int         nf;
      int         nw;
      logic [7:0] sum;
      logic [7:0] b;
      for (int it = 0; it < 6; it++) begin
         do_reset(1'b0, "random");
         stream.delete();
         nf = int'($urandom_range(4, 1));
         for (int f = 0; f < nf; f++) begin
            repeat ($urandom_range(2, 0)) begin
               b = 8'($urandom_range(255, 0));
               if (b == 8'hA5) b = 8'h00;
               stream.push_back(b);
            end
            stream.push_back(8'hA5);
            nw = int'($urandom_range(6, 0));
            stream.push_back(8'(nw));
            sum = 8'd0;
            for (int w = 0; w < 2 * nw; w++) begin
               b = 8'($urandom_range(255, 0));
               stream.push_back(b);
               sum = sum + b;
            end
            if (nw != 0) stream.push_back(($urandom_range(2, 0) == 0) ? sum : sum + 8'd1);
         end
         model_parse();
         run_bytes(0, stream.size(), 3, "random");
         check_final("random");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bad_then_good();
      test_garbage();
      test_zero_len();
      test_gapped();
      test_reset_mid();
      test_full_length();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
